// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong loader turning a complex sample stream into parallel FFT frames
// Define FFT_LOADER_BITREV_EN to store samples at bit-reversed addresses; default is natural order.
module fft_frame_loader #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  output logic signed [WIDTH-1:0] frame_r [0:N-1],
  output logic signed [WIDTH-1:0] frame_i [0:N-1],
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [15:0]             frame_cnt,
  output logic                    resync_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_e;

  bank_state_e             state_q [0:1];
  bank_state_e             state_d [0:1];
  logic                    fill_q, fill_d;
  logic                    out_q, out_d;
  logic [LOG2N-1:0]        cnt_q, cnt_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    resync_err_q, resync_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic signed [WIDTH-1:0] mem_r_q [0:1][0:N-1];
  logic signed [WIDTH-1:0] mem_i_q [0:1][0:N-1];
  logic                    accept, xfer, resync;
  logic [LOG2N-1:0]        slot, wr_addr;

  function automatic logic [LOG2N-1:0] map_addr(input logic [LOG2N-1:0] c);
    logic [LOG2N-1:0] a;
`ifdef FFT_LOADER_BITREV_EN
    a = '0;
    for (int b = 0; b < LOG2N; b++) a[b] = c[LOG2N-1-b];
`else
    a = c;
`endif
    return a;
  endfunction

  always_comb begin
    accept        = in_valid && in_ready_q;
    xfer          = frame_valid_q && frame_ready;
    resync        = accept && in_first && (cnt_q != '0);
    slot          = resync ? '0 : cnt_q;
    wr_addr       = map_addr(slot);
    state_d[0]    = state_q[0];
    state_d[1]    = state_q[1];
    fill_d        = fill_q;
    out_d         = out_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    resync_err_d  = resync;
    if (xfer) begin
      state_d[out_q] = EMPTY;
      out_d          = ~out_q;
      frame_cnt_d    = frame_cnt_q + 16'd1;
    end
    if (accept) begin
      if (slot == LOG2N'(N-1)) begin
        state_d[fill_q] = FULL;
        cnt_d           = '0;
      end else begin
        state_d[fill_q] = FILLING;
        cnt_d           = slot + LOG2N'(1);
      end
    end
    // Filling only hops banks once the other one is free; with both FULL it waits for a transfer.
    if (state_d[fill_q] == FULL && state_d[~fill_q] == EMPTY) fill_d = ~fill_q;
    frame_valid_d = (state_d[out_d] == FULL);
    in_ready_d    = (state_d[0] != FULL) || (state_d[1] != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]    <= EMPTY;
      state_q[1]    <= EMPTY;
      fill_q        <= 1'b0;
      out_q         <= 1'b0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
      resync_err_q  <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q[0]    <= state_d[0];
      state_q[1]    <= state_d[1];
      fill_q        <= fill_d;
      out_q         <= out_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      in_ready_q    <= in_ready_d;
      resync_err_q  <= resync_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_r_q[fill_q][wr_addr] <= in_r;
      mem_i_q[fill_q][wr_addr] <= in_i;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      frame_r[k] = rst ? '0 : mem_r_q[out_q][k];
      frame_i[k] = rst ? '0 : mem_i_q[out_q][k];
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign resync_err  = resync_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - self-checking bench for fft_frame_loader with a frame-queue reference model
module tb_fft_frame_loader;
  localparam int WIDTH = 32;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, in_ready, in_first;
  logic                    frame_valid, frame_ready, resync_err;
  logic signed [WIDTH-1:0] in_r, in_i;
  logic signed [WIDTH-1:0] frame_r [0:N-1];
  logic signed [WIDTH-1:0] frame_i [0:N-1];
  logic [15:0]             frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: completed frames waiting for the core, plus the partial frame being collected.
  logic [N*WIDTH-1:0] q_r [$];
  logic [N*WIDTH-1:0] q_i [$];
  logic [N*WIDTH-1:0] p_r, p_i;
  int                 p_cnt = 0;
  logic [15:0]        m_cnt = 16'd0;
  logic               m_err = 1'b0;

  always #5 clk = ~clk;

  fft_frame_loader #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_r(in_r), .in_i(in_i), .frame_r(frame_r), .frame_i(frame_i), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_cnt(frame_cnt), .resync_err(resync_err)
  );

  function automatic int addr_of(int k);
    int r;
    r = k;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG2N; b++)
      if (((k >> b) & 1) != 0) r = r + (1 << (LOG2N - 1 - b));
`endif
    return r;
  endfunction

  task automatic step();
    logic acc, xfer;
    acc  = in_valid && (q_r.size() < 2);
    xfer = frame_ready && (q_r.size() > 0);
    @(posedge clk);
    if (rst) begin
      q_r.delete(); q_i.delete();
      p_cnt = 0; m_cnt = 16'd0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (xfer) begin
        void'(q_r.pop_front()); void'(q_i.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) begin
        if (in_first && p_cnt != 0) begin p_cnt = 0; m_err = 1'b1; end
        p_r[p_cnt*WIDTH +: WIDTH] = in_r;
        p_i[p_cnt*WIDTH +: WIDTH] = in_i;
        p_cnt++;
        if (p_cnt == N) begin q_r.push_back(p_r); q_i.push_back(p_i); p_cnt = 0; end
      end
    end
    #1;
  endtask

  task automatic send(input int r, input logic first);
    in_valid = 1'b1; in_first = first; in_r = r; in_i = 0;
    step();
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; frame_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_r = 0; in_i = 0; frame_ready = 1'b0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (resync_err !== 1'b0) begin n_bad++; $display("FAIL reset_resync_err: got %b want 0", resync_err); end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (frame_r[k] !== 0 || frame_i[k] !== 0) begin
        n_bad++; $display("FAIL reset_frame_zero[%0d]: got %0d/%0d want 0/0", k, frame_r[k], frame_i[k]);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_order();
    int exp_r [N];
`ifdef FFT_LOADER_BITREV_EN
    exp_r = '{1, 5, 3, 7, 2, 6, 4, 8};
`else
    exp_r = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif
    do_reset();
    for (int s = 1; s <= N; s++) begin
      send(s, 1'b0);
      if (s == N - 1) begin
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL order_early_valid: got %b want 0", frame_valid); end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid_latency: got %b want 1", frame_valid); end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (frame_r[k] !== exp_r[k] || frame_i[k] !== 0) begin
        n_bad++; $display("FAIL order_frame[%0d]: got %0d/%0d want %0d/0", k, frame_r[k], frame_i[k], exp_r[k]);
      end
    end
    step();
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_r[N-1] !== exp_r[N-1]) begin
      n_bad++; $display("FAIL order_hold: got valid=%b r7=%0d want valid=1 r7=%0d", frame_valid, frame_r[N-1], exp_r[N-1]);
    end
    frame_ready = 1'b1; step(); frame_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL order_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL order_drained: got %b want 0", frame_valid); end
  endtask

  task automatic test_backpressure();
    logic [N*WIDTH-1:0] f;
    do_reset();
    for (int s = 0; s < 2*N; s++) send(int'($urandom_range(0, 1000)), 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full_valid: got %b want 1", frame_valid); end
    send(777, 1'b0);
    n_cmp++; if (in_ready !== 1'b0 || frame_cnt !== 16'd0) begin
      n_bad++; $display("FAIL bp_stall: got ready=%b cnt=%0d want 0/0", in_ready, frame_cnt);
    end
    frame_ready = 1'b1; step(); frame_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL bp_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
    f = q_r[0];
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (frame_r[addr_of(k)] !== f[k*WIDTH +: WIDTH]) begin
        n_bad++; $display("FAIL bp_second_frame[%0d]: got %0d want %0d", k, frame_r[addr_of(k)], f[k*WIDTH +: WIDTH]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_ready = 1'b1;
    for (int s = 0; s < 3*N; s++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", s, in_ready); end
      send(s + 100, 1'b0);
    end
    step();
    frame_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 3", frame_cnt); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", frame_valid); end
  endtask

  task automatic test_resync();
    do_reset();
    send(10, 1'b1);
    n_cmp++; if (resync_err !== 1'b0) begin n_bad++; $display("FAIL resync_first_at_zero: got %b want 0", resync_err); end
    send(11, 1'b0); send(12, 1'b0);
    in_first = 1'b1; step(); in_first = 1'b0;
    n_cmp++; if (resync_err !== 1'b0) begin n_bad++; $display("FAIL resync_unqualified: got %b want 0", resync_err); end
    send(99, 1'b1);
    n_cmp++; if (resync_err !== 1'b1) begin n_bad++; $display("FAIL resync_pulse: got %b want 1", resync_err); end
    send(50, 1'b0);
    n_cmp++; if (resync_err !== 1'b0) begin n_bad++; $display("FAIL resync_one_cycle: got %b want 0", resync_err); end
    for (int s = 1; s < N - 1; s++) send(50 + s, 1'b0);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL resync_valid: got %b want 1", frame_valid); end
    n_cmp++; if (frame_r[0] !== 99) begin n_bad++; $display("FAIL resync_point0: got %0d want 99", frame_r[0]); end
    n_cmp++; if (frame_r[addr_of(1)] !== 50) begin n_bad++; $display("FAIL resync_point1: got %0d want 50", frame_r[addr_of(1)]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame_ready = 1'b1;
    for (int s = 0; s < N; s++) send(s, 1'b0);
    step();
    frame_ready = 1'b0;
    for (int s = 0; s < 5; s++) send(200 + s, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", frame_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", frame_cnt); end
    for (int s = 0; s < N; s++) send(21 + s, 1'b0);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_clean_valid: got %b want 1", frame_valid); end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (frame_r[addr_of(k)] !== 21 + k) begin
        n_bad++; $display("FAIL rmid_clean[%0d]: got %0d want %0d", k, frame_r[addr_of(k)], 21 + k);
      end
    end
  endtask

  task automatic test_random();
    logic [N*WIDTH-1:0] fr, fi;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_first    = ($urandom_range(0, 15) == 0);
      in_r        = $urandom;
      in_i        = $urandom;
      frame_ready = ($urandom_range(0, 2) == 0);
      step();
      n_cmp++; if (in_ready !== (q_r.size() < 2)) begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, q_r.size() < 2); end
      n_cmp++; if (frame_valid !== (q_r.size() > 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, frame_valid, q_r.size() > 0); end
      n_cmp++; if (resync_err !== m_err) begin n_bad++; $display("FAIL rnd_resync@%0d: got %b want %b", c, resync_err, m_err); end
      n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, frame_cnt, m_cnt); end
      if (q_r.size() > 0 && !rst) begin
        fr = q_r[0]; fi = q_i[0];
        for (int k = 0; k < N; k++) begin
          n_cmp++;
          if (frame_r[addr_of(k)] !== fr[k*WIDTH +: WIDTH] || frame_i[addr_of(k)] !== fi[k*WIDTH +: WIDTH]) begin
            n_bad++;
            $display("FAIL rnd_frame@%0d[%0d]: got %h/%h want %h/%h", c, k, frame_r[addr_of(k)], frame_i[addr_of(k)],
                     fr[k*WIDTH +: WIDTH], fi[k*WIDTH +: WIDTH]);
          end
        end
      end
    end
    rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; frame_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of each real and imaginary sample part (signed).
REQ-002 SHALL have parameter N, default 8, meaning the number of complex points per frame (power of two).
REQ-003 SHALL have parameter LOG2N, default 3, meaning log2(N).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  meaning the input sample is valid.
REQ-007 SHALL have port in_ready  output  1  meaning the loader can accept a sample.
REQ-008 SHALL have port in_first  input  1  meaning the qualified sample is point 0 of a new frame.
REQ-009 SHALL have ports in_r and in_i  input  WIDTH signed each  meaning the real and imaginary parts of the sample.
REQ-010 SHALL have ports frame_r and frame_i  output  WIDTH signed x [0:N-1] each  meaning the parallel frame passed to the FFT core.
REQ-011 SHALL have port frame_valid  output  1  meaning the frame arrays hold a complete frame.
REQ-012 SHALL have port frame_ready  input  1  meaning the FFT core takes the frame.
REQ-013 SHALL have port frame_cnt  output  16  meaning the number of frames delivered, modulo 2^16.
REQ-014 SHALL have port resync_err  output  1  meaning a one-cycle pulse when a partial frame is discarded.

Function
REQ-015 SHALL accept a sample only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL use two ping-pong banks, each N complex words; each bank is in state EMPTY, FILLING or FULL.
REQ-017 SHALL write accepted sample number c (0..N-1) of the current frame to address bitrev(c) of the fill bank, with bit reversal over LOG2N bits.
REQ-018 SHALL mark the fill bank FULL when sample N-1 is accepted, and move filling to the other bank if that bank is EMPTY.
REQ-019 SHALL drive in_ready=1 exactly when a bank is EMPTY or FILLING; in_ready depends only on registered state, not on frame_ready.
REQ-020 SHALL assert frame_valid on the cycle after the last sample of a frame is accepted (latency 1), presenting the oldest FULL bank.
REQ-021 SHALL hold frame_r, frame_i and frame_valid stable while frame_valid=1 and frame_ready=0.
REQ-022 SHALL treat frame_valid=1 and frame_ready=1 as a transfer: the presented bank becomes EMPTY next cycle and frame_cnt increments, wrapping from 65535 to 0.
REQ-023 SHALL perform both actions when a transfer and a final-sample acceptance occur in the same cycle; in_ready stays 1, and the new frame becomes frame_valid next cycle.
REQ-024 SHALL, when both banks are FULL, hold in_ready=0 until a transfer; in_ready rises on the cycle after the transfer.
REQ-025 SHALL, on an accepted sample with in_first=1 while the sample count is nonzero, discard the partial frame, write the sample as point 0, and pulse resync_err for one cycle.
REQ-026 SHALL treat in_first=1 with count 0 as a normal sample, with no error.
REQ-027 SHALL ignore in_first when the sample is not accepted.
REQ-028 SHALL store samples bit-exact, with no arithmetic or width change.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set both banks EMPTY, the sample count to 0, frame_valid=0, frame_cnt=0 and resync_err=0; in_ready=1 after reset.
REQ-030 SHALL discard any partial or FULL frame on reset mid-operation; the bank data contents need not be cleared.
REQ-031 SHALL drive frame_r and frame_i to 0 during reset.

Configuration
REQ-032 SHALL use macro FFT_LOADER_BITREV_EN: when defined, write addresses are bitrev(c) per REQ-017; when undefined, the write address is c (natural order) and all other behaviour is unchanged.

Verification
REQ-033 SHALL check, with BITREV_EN defined, N=8, samples in_r=1..8, in_i=0 and frame_ready=0: frame_valid=1 one cycle after the 8th sample, frame_r = {1,5,3,7,2,6,4,8}.
REQ-034 SHALL check, with the macro undefined and the same stimulus: frame_r = {1,2,3,4,5,6,7,8}.
REQ-035 SHALL check, with frame_ready=0 and 16 samples streamed: in_ready=0 after the 16th sample; one frame_ready pulse gives frame_cnt=1, and in_ready=1 the next cycle.
REQ-036 SHALL check, with frame_ready=1 held and 24 samples back-to-back: in_ready stays 1, three transfers occur, frame_cnt=3.
REQ-037 SHALL check 3 samples, then a sample with in_first=1 and value 99: resync_err pulses once; after 7 more samples, frame_r[0]=99.
REQ-038 SHALL check rst asserted after 5 samples: frame_valid=0, in_ready=1, frame_cnt=0; the next 8 samples form a clean frame.
